// File: rtl/uart_cmd_controller.sv
// rtl/uart_cmd_controller.sv - UART command sequencer for the delay-line datapath (optional echo: UART_ECHO_EN)

`ifndef UART_MSG_WIDTH
`define UART_MSG_WIDTH 64
`endif
`ifndef UART_HEADER_BITS
`define UART_HEADER_BITS 7:0
`endif
`ifndef UART_PAYLOAD_BITS
`define UART_PAYLOAD_BITS 63:8
`endif
`ifndef UART_PAYLOAD_WIDTH
`define UART_PAYLOAD_WIDTH 56
`endif
`ifndef UART_HDR_SYS_STATUS
`define UART_HDR_SYS_STATUS 8'h01
`endif
`ifndef UART_HDR_MEM_PARAMS
`define UART_HDR_MEM_PARAMS 8'h02
`endif
`ifndef UART_HDR_MOD_PARAMS
`define UART_HDR_MOD_PARAMS 8'h03
`endif
`ifndef UART_HDR_DEMOD_PARAMS
`define UART_HDR_DEMOD_PARAMS 8'h04
`endif
`ifndef UART_HDR_REPLACE_NUM
`define UART_HDR_REPLACE_NUM 8'h05
`endif
`ifndef UART_MEM_PARAMS_NO_NUMS_PAYLOAD_BITS
`define UART_MEM_PARAMS_NO_NUMS_PAYLOAD_BITS 16:1
`define UART_MEM_PARAMS_NO_NUMS_PAYLOAD_WIDTH 16
`endif
`ifndef UART_MEM_PARAMS_TEST_MODE_PAYLOAD_BITS
`define UART_MEM_PARAMS_TEST_MODE_PAYLOAD_BITS 17:17
`define UART_MEM_PARAMS_TEST_MODE_PAYLOAD_WIDTH 1
`endif
`ifndef UART_MEM_PARAMS_PULSE_WIDTH_PAYLOAD_BITS
`define UART_MEM_PARAMS_PULSE_WIDTH_PAYLOAD_BITS 25:18
`define UART_MEM_PARAMS_PULSE_WIDTH_PAYLOAD_WIDTH 8
`endif
`ifndef UART_MEM_PARAMS_PULSE_GAP_PAYLOAD_BITS
`define UART_MEM_PARAMS_PULSE_GAP_PAYLOAD_BITS 33:26
`define UART_MEM_PARAMS_PULSE_GAP_PAYLOAD_WIDTH 8
`endif
`ifndef UART_MOD_PARAMS_CYCLES_PER_HALF_PERIOD_PAYLOAD_BITS
`define UART_MOD_PARAMS_CYCLES_PER_HALF_PERIOD_PAYLOAD_BITS 16:1
`define UART_MOD_PARAMS_CYCLES_PER_HALF_PERIOD_PAYLOAD_WIDTH 16
`endif
`ifndef UART_DEMOD_PARAMS_PULSE_WIDTH_PAYLOAD_BITS
`define UART_DEMOD_PARAMS_PULSE_WIDTH_PAYLOAD_BITS 8:1
`define UART_DEMOD_PARAMS_PULSE_WIDTH_PAYLOAD_WIDTH 8
`endif
`ifndef UART_REPLACE_NUM_ADDR_PAYLOAD_BITS
`define UART_REPLACE_NUM_ADDR_PAYLOAD_BITS 16:1
`define UART_REPLACE_NUM_ADDR_PAYLOAD_WIDTH 16
`endif
`ifndef UART_REPLACE_NUM_DATA_PAYLOAD_BITS
`define UART_REPLACE_NUM_DATA_PAYLOAD_BITS 32:17
`define UART_REPLACE_NUM_DATA_PAYLOAD_WIDTH 16
`endif

module uart_cmd_controller #(
    parameter int DATA_WIDTH     = 8,
    parameter int MSG_WIDTH      = `UART_MSG_WIDTH,
    parameter int TIMEOUT_CYCLES = 112500
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] rx_data,
    input  logic                  rx_valid,
    output logic [DATA_WIDTH-1:0] tx_data,
    output logic                  tx_valid,
    input  logic                  tx_ready,
    output logic                  run,
    output logic [`UART_MEM_PARAMS_NO_NUMS_PAYLOAD_WIDTH-1:0]                mem_no_nums,
    output logic [`UART_MEM_PARAMS_TEST_MODE_PAYLOAD_WIDTH-1:0]              mem_test_mode,
    output logic [`UART_MEM_PARAMS_PULSE_WIDTH_PAYLOAD_WIDTH-1:0]            mem_pulse_width,
    output logic [`UART_MEM_PARAMS_PULSE_GAP_PAYLOAD_WIDTH-1:0]              mem_pulse_gap,
    output logic [`UART_MOD_PARAMS_CYCLES_PER_HALF_PERIOD_PAYLOAD_WIDTH-1:0] mod_half_period,
    output logic [`UART_DEMOD_PARAMS_PULSE_WIDTH_PAYLOAD_WIDTH-1:0]          demod_pulse_width,
    output logic                  params_load,
    output logic [`UART_REPLACE_NUM_ADDR_PAYLOAD_WIDTH-1:0] replace_addr,
    output logic [`UART_REPLACE_NUM_DATA_PAYLOAD_WIDTH-1:0] replace_data,
    output logic                  replace_valid,
    input  logic                  replace_ready,
    output logic                  err
);

    localparam int NUM_BYTES = MSG_WIDTH / DATA_WIDTH;
    localparam int CNT_W     = $clog2(NUM_BYTES + 1);
    localparam int IDLE_W    = $clog2(TIMEOUT_CYCLES + 1);

`ifdef UART_ECHO_EN
    typedef enum logic [1:0] {ST_ASSEMBLE, ST_DECODE, ST_EXEC, ST_RESP} state_t;
`else
    typedef enum logic [1:0] {ST_ASSEMBLE, ST_DECODE, ST_EXEC} state_t;
`endif

    state_t state, next_state;

    logic [MSG_WIDTH-1:0]           msg;
    logic [CNT_W-1:0]               byte_cnt;
    logic [IDLE_W-1:0]              idle_cnt;
    logic [7:0]                     header;
    logic [`UART_PAYLOAD_WIDTH-1:0] payload;
    logic                           is_param;
    logic                           is_replace;
    logic                           accept;
    logic                           last_byte;
    logic                           timeout_hit;

    assign header  = msg[`UART_HEADER_BITS];
    assign payload = msg[`UART_PAYLOAD_BITS];

`ifdef UART_ECHO_EN
    logic [MSG_WIDTH-1:0] resp_msg;
    logic [CNT_W-1:0]     tx_cnt;
`else
    logic unused_bits;
    assign unused_bits = ^{tx_ready, payload};
`endif

    // Message classification and acceptance rule (params only when stopped, writes only when running)
    always_comb begin
        is_param    = (header == `UART_HDR_MEM_PARAMS) || (header == `UART_HDR_MOD_PARAMS) ||
                      (header == `UART_HDR_DEMOD_PARAMS);
        is_replace  = (header == `UART_HDR_REPLACE_NUM);
        accept      = (header == `UART_HDR_SYS_STATUS) || (is_param && !run) || (is_replace && run);
        last_byte   = (state == ST_ASSEMBLE) && rx_valid && (byte_cnt == CNT_W'(NUM_BYTES - 1));
        timeout_hit = (state == ST_ASSEMBLE) && !rx_valid && (byte_cnt != '0) &&
                      (idle_cnt == IDLE_W'(TIMEOUT_CYCLES));
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) state <= ST_ASSEMBLE;
        else     state <= next_state;
    end

    // FSM next-state logic
    always_comb begin
        next_state = state;
        case (state)
            ST_ASSEMBLE: if (last_byte) next_state = ST_DECODE;
`ifdef UART_ECHO_EN
            ST_DECODE:   next_state = (accept && is_replace) ? ST_EXEC : ST_RESP;
            ST_EXEC:     if (replace_ready) next_state = ST_RESP;
            ST_RESP:     if (tx_ready && (tx_cnt == CNT_W'(NUM_BYTES - 1))) next_state = ST_ASSEMBLE;
`else
            ST_DECODE:   next_state = (accept && is_replace) ? ST_EXEC : ST_ASSEMBLE;
            ST_EXEC:     if (replace_ready) next_state = ST_ASSEMBLE;
`endif
            default:     next_state = ST_ASSEMBLE;
        endcase
    end

    // FSM outputs: write request and response byte stream
    always_comb begin
        replace_valid = (state == ST_EXEC);
`ifdef UART_ECHO_EN
        tx_valid = (state == ST_RESP);
        tx_data  = resp_msg[DATA_WIDTH-1:0];
`else
        tx_valid = 1'b0;
        tx_data  = '0;
`endif
    end

    // Datapath: byte assembly, inter-byte timeout, decode side effects and error flag
    always_ff @(posedge clk) begin
        if (rst) begin
            msg               <= '0;
            byte_cnt          <= '0;
            idle_cnt          <= '0;
            run               <= 1'b0;
            mem_no_nums       <= '0;
            mem_test_mode     <= '0;
            mem_pulse_width   <= '0;
            mem_pulse_gap     <= '0;
            mod_half_period   <= '0;
            demod_pulse_width <= '0;
            params_load       <= 1'b0;
            replace_addr      <= '0;
            replace_data      <= '0;
            err               <= 1'b0;
`ifdef UART_ECHO_EN
            resp_msg          <= '0;
            tx_cnt            <= '0;
`endif
        end else begin
            params_load <= 1'b0;
            case (state)
                ST_ASSEMBLE: begin
                    if (rx_valid) begin
                        msg      <= {rx_data, msg[MSG_WIDTH-1:DATA_WIDTH]};
                        idle_cnt <= '0;
                        byte_cnt <= last_byte ? '0 : byte_cnt + CNT_W'(1);
                    end else if (timeout_hit) begin
                        byte_cnt <= '0;
                        idle_cnt <= '0;
                        err      <= 1'b1;
                    end else if (byte_cnt != '0) begin
                        idle_cnt <= idle_cnt + IDLE_W'(1);
                    end
                end
                ST_DECODE: begin
                    err <= !accept;
                    case (header)
                        `UART_HDR_SYS_STATUS: run <= payload[0];
                        `UART_HDR_MEM_PARAMS: if (!run) begin
                            mem_no_nums     <= payload[`UART_MEM_PARAMS_NO_NUMS_PAYLOAD_BITS];
                            mem_test_mode   <= payload[`UART_MEM_PARAMS_TEST_MODE_PAYLOAD_BITS];
                            mem_pulse_width <= payload[`UART_MEM_PARAMS_PULSE_WIDTH_PAYLOAD_BITS];
                            mem_pulse_gap   <= payload[`UART_MEM_PARAMS_PULSE_GAP_PAYLOAD_BITS];
                            params_load     <= 1'b1;
                        end
                        `UART_HDR_MOD_PARAMS: if (!run) begin
                            mod_half_period <= payload[`UART_MOD_PARAMS_CYCLES_PER_HALF_PERIOD_PAYLOAD_BITS];
                            params_load     <= 1'b1;
                        end
                        `UART_HDR_DEMOD_PARAMS: if (!run) begin
                            demod_pulse_width <= payload[`UART_DEMOD_PARAMS_PULSE_WIDTH_PAYLOAD_BITS];
                            params_load       <= 1'b1;
                        end
                        `UART_HDR_REPLACE_NUM: if (run) begin
                            replace_addr <= payload[`UART_REPLACE_NUM_ADDR_PAYLOAD_BITS];
                            replace_data <= payload[`UART_REPLACE_NUM_DATA_PAYLOAD_BITS];
                        end
                        default: ;
                    endcase
`ifdef UART_ECHO_EN
                    resp_msg <= {payload[`UART_PAYLOAD_WIDTH-1:1], accept, header};
                    tx_cnt   <= '0;
`endif
                end
`ifdef UART_ECHO_EN
                ST_RESP: begin
                    if (tx_ready) begin
                        resp_msg <= resp_msg >> DATA_WIDTH;
                        tx_cnt   <= tx_cnt + CNT_W'(1);
                    end
                end
`endif
                default: ;
            endcase
            // A byte arriving while busy is dropped; it must override the decode-time clear
            if (rx_valid && (state != ST_ASSEMBLE)) err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_uart_cmd_controller.sv
// tb/tb_uart_cmd_controller.sv - randomized model-checked bench for uart_cmd_controller
module tb_uart_cmd_controller;

    localparam int T = 200;

    logic        clk;
    logic        rst;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        run;
    logic [15:0] mem_no_nums;
    logic        mem_test_mode;
    logic [7:0]  mem_pulse_width;
    logic [7:0]  mem_pulse_gap;
    logic [15:0] mod_half_period;
    logic [7:0]  demod_pulse_width;
    logic        params_load;
    logic [15:0] replace_addr;
    logic [15:0] replace_data;
    logic        replace_valid;
    logic        replace_ready;
    logic        err;

    uart_cmd_controller #(.DATA_WIDTH(8), .MSG_WIDTH(64), .TIMEOUT_CYCLES(T)) dut (
        .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready), .run(run),
        .mem_no_nums(mem_no_nums), .mem_test_mode(mem_test_mode),
        .mem_pulse_width(mem_pulse_width), .mem_pulse_gap(mem_pulse_gap),
        .mod_half_period(mod_half_period), .demod_pulse_width(demod_pulse_width),
        .params_load(params_load), .replace_addr(replace_addr), .replace_data(replace_data),
        .replace_valid(replace_valid), .replace_ready(replace_ready), .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int n_xfer = 0;
    int echo_idx = 0;
    bit chk_en = 0;
    logic [7:0] echo_buf [8];

    // Reference model state
    logic        m_run, m_tm, m_pl, m_err, m_rv;
    logic [15:0] m_no, m_half, m_ra, m_rd;
    logic [7:0]  m_pw, m_pg, m_demod;
    logic [7:0]  exp_tx [$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_run = 0; m_tm = 0; m_pl = 0; m_err = 0; m_rv = 0;
        m_no = 0; m_half = 0; m_ra = 0; m_rd = 0;
        m_pw = 0; m_pg = 0; m_demod = 0;
        exp_tx.delete();
    endtask

    function automatic logic [63:0] mk(input logic [7:0] h, input logic [55:0] p);
        return {p, h};
    endfunction

    function automatic logic [55:0] mem_pay(input logic [15:0] nn, input logic tm,
                                            input logic [7:0] pw, input logic [7:0] pg);
        logic [55:0] p;
        p = '0; p[16:1] = nn; p[17] = tm; p[25:18] = pw; p[33:26] = pg;
        return p;
    endfunction

    function automatic logic [55:0] rep_pay(input logic [15:0] a, input logic [15:0] d);
        logic [55:0] p;
        p = '0; p[16:1] = a; p[32:17] = d;
        return p;
    endfunction

    // Message semantics at the transaction level
    task automatic decode_model(input logic [63:0] msg);
        logic [7:0]  h;
        logic [55:0] p;
        logic        acc;
        logic [63:0] resp;
        h = msg[7:0]; p = msg[63:8]; acc = 0;
        case (h)
            8'h01: begin m_run = p[0]; acc = 1; end
            8'h02: if (!m_run) begin m_no = p[16:1]; m_tm = p[17]; m_pw = p[25:18]; m_pg = p[33:26]; m_pl = 1; acc = 1; end
            8'h03: if (!m_run) begin m_half = p[16:1]; m_pl = 1; acc = 1; end
            8'h04: if (!m_run) begin m_demod = p[8:1]; m_pl = 1; acc = 1; end
            8'h05: if (m_run) begin m_ra = p[16:1]; m_rd = p[32:17]; m_rv = 1; acc = 1; end
            default: ;
        endcase
        m_err = !acc;
`ifdef UART_ECHO_EN
        resp = msg;
        resp[8] = acc;
        for (int i = 0; i < 8; i++) exp_tx.push_back(resp[8*i +: 8]);
`endif
    endtask

    // Every-cycle comparison of DUT outputs against the model
    always @(negedge clk) begin
        if (chk_en) begin
            chk("run", run, m_run);
            chk("mem_no_nums", mem_no_nums, m_no);
            chk("mem_test_mode", mem_test_mode, m_tm);
            chk("mem_pulse_width", mem_pulse_width, m_pw);
            chk("mem_pulse_gap", mem_pulse_gap, m_pg);
            chk("mod_half_period", mod_half_period, m_half);
            chk("demod_pulse_width", demod_pulse_width, m_demod);
            chk("params_load", params_load, m_pl);
            chk("err", err, m_err);
            chk("replace_valid", replace_valid, m_rv);
            if (m_rv) begin
                chk("replace_addr", replace_addr, m_ra);
                chk("replace_data", replace_data, m_rd);
            end
            if (replace_valid && replace_ready) n_xfer++;
`ifdef UART_ECHO_EN
            if (tx_valid) begin
                if (exp_tx.size() == 0) chk("tx_valid_unexpected", tx_valid, 0);
                else begin
                    chk("tx_data", tx_data, exp_tx[0]);
                    if (tx_ready) begin
                        if (echo_idx < 8) echo_buf[echo_idx] = tx_data;
                        echo_idx++;
                        void'(exp_tx.pop_front());
                    end
                end
            end
`else
            chk("tx_valid", tx_valid, 0);
            chk("tx_data", tx_data, 0);
`endif
        end
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_data = b; rx_valid = 1; tick(); rx_valid = 0;
    endtask

    task automatic send_bytes(input logic [63:0] msg, input int from, input int to, input int gap);
        for (int i = from; i <= to; i++) begin
            repeat ($urandom_range(0, gap)) tick();
            send_byte(msg[8*i +: 8]);
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_tx.size() > 0 && n < 200) begin tick(); n++; end
        if (exp_tx.size() > 0) begin
            chk("echo_drain_pending", 64'(exp_tx.size()), 0);
            exp_tx.delete();
        end
    endtask

    task automatic finish_msg(input logic [63:0] msg);
        tick();
        decode_model(msg);
        tick();
        m_pl = 0;
        if (!m_rv) drain();
    endtask

    task automatic send_msg(input logic [63:0] msg, input int gap);
        send_bytes(msg, 0, 7, gap);
        finish_msg(msg);
    endtask

    task automatic do_replace(input int hold, input int inject_at);
        for (int i = 0; i < hold; i++) begin
            if (i == inject_at) begin rx_data = 8'($urandom); rx_valid = 1; end
            tick();
            if (rx_valid) begin rx_valid = 0; m_err = 1; end
        end
        replace_ready = 1; tick(); replace_ready = 0; m_rv = 0;
        drain();
    endtask

    initial begin
        tx_ready = 0;
        forever begin tick(); tx_ready = ~tx_ready; end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [63:0] r, msg;
        logic [7:0]  h;
        int          kind, x0;
        rst = 1; rx_data = 0; rx_valid = 0; replace_ready = 0;
        model_reset();
        tick();
        chk_en = 1;
        tick(); tick();
        rst = 0;
        tick();
        chk("reset_run", run, 0);
        chk("reset_err", err, 0);

        // Run / stop
        send_msg(mk(8'h01, 56'h1), 0);
        chk("sys_run_on", run, 1);
        send_msg(mk(8'h01, 56'h0), 2);
        chk("sys_run_off", run, 0);
        chk("sys_err", err, 0);

        // Parameter loads while stopped
        send_msg(mk(8'h02, mem_pay(16, 0, 49, 54)), 1);
        chk("mem_no_nums_lit", mem_no_nums, 16);
        chk("mem_pulse_width_lit", mem_pulse_width, 49);
        chk("mem_pulse_gap_lit", mem_pulse_gap, 54);
        send_msg(mk(8'h03, 56'h2 << 1), 0);
        chk("mod_half_lit", mod_half_period, 2);
        send_msg(mk(8'h04, 56'd81 << 1), 0);
        chk("demod_pw_lit", demod_pulse_width, 81);

        // Rejections
        send_msg(mk(8'h01, 56'h1), 0);
        send_msg(mk(8'h02, mem_pay(8, 1, 1, 1)), 0);
        chk("mem_reject_keep", mem_no_nums, 16);
        chk("mem_reject_err", err, 1);
        send_msg(mk(8'h01, 56'h0), 0);
        send_msg(mk(8'h05, rep_pay(1, 3)), 0);
        chk("replace_reject_err", err, 1);
        chk("replace_reject_valid", replace_valid, 0);

        // Write handshake with back-pressure and a stray byte
        send_msg(mk(8'h01, 56'h1), 0);
        n_xfer = 0;
        send_msg(mk(8'h05, rep_pay(1, 3)), 0);
        chk("replace_addr_lit", replace_addr, 1);
        chk("replace_data_lit", replace_data, 3);
        do_replace(10, 5);
        chk("replace_xfers", n_xfer, 1);
        chk("stray_byte_err", err, 1);

`ifdef UART_ECHO_EN
        echo_idx = 0;
        send_msg(mk(8'h04, 56'd81 << 1), 1);
        chk("echo_rej_hdr", echo_buf[0], 8'h04);
        chk("echo_rej_pay", echo_buf[1], 8'hA2);
        send_msg(mk(8'h01, 56'h0), 0);
        echo_idx = 0;
        send_msg(mk(8'h04, 56'd81 << 1), 1);
        chk("echo_acc_hdr", echo_buf[0], 8'h04);
        chk("echo_acc_pay", echo_buf[1], 8'hA3);
`endif

        // Inter-byte gap of exactly T idle clocks is tolerated
        msg = mk(8'h01, 56'h0);
        send_bytes(msg, 0, 2, 0);
        repeat (T) tick();
        send_bytes(msg, 3, 7, 0);
        finish_msg(msg);
        chk("gap_T_ok_err", err, 0);

        // One more idle clock discards the partial message
        send_bytes(mk(8'h01, 56'h1), 0, 2, 0);
        repeat (T) tick();
        tick();
        m_err = 1;
        chk("timeout_err", err, 1);
        send_msg(mk(8'h01, 56'h1), 0);
        chk("after_timeout_run", run, 1);
        chk("after_timeout_err", err, 0);

        // Reset in the middle of a write handshake
        send_msg(mk(8'h05, rep_pay(16'h55, 16'hAA)), 0);
        tick(); tick();
        rst = 1; tick(); model_reset(); rst = 0;
        chk("rst_replace_valid", replace_valid, 0);
        chk("rst_run", run, 0);
        tick();

        // Randomized traffic
        for (int k = 0; k < 40; k++) begin
            r = {$urandom(), $urandom()};
            kind = $urandom_range(0, 6);
            case (kind)
                0: h = 8'h01;
                1: h = 8'h02;
                2: h = 8'h03;
                3: h = 8'h04;
                4, 5: h = 8'h05;
                default: h = ($urandom_range(0, 1) == 0) ? 8'h00 : 8'($urandom_range(6, 255));
            endcase
            send_msg(mk(h, r[55:0]), 3);
            if (m_rv) begin
                x0 = ($urandom_range(0, 2) == 0) ? $urandom_range(0, 4) : -1;
                do_replace($urandom_range(0, 5), x0);
            end
            repeat ($urandom_range(0, 3)) tick();
        end

        tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
